// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC stage and decode: one ROM fetch in flight, head visible 2 cycles after issue.
// Backpressure: oPcHold freezes the PC once buffered plus in-flight words reach QUEUE_DEPTH; redirects flush everything.
module fetch_queue #(
    parameter int INSTR_WIDTH = 16,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [9:0]             iIP,
    input  logic                   iBranchTaken,
    input  logic                   iJumpTaken,
    output logic [9:0]             oRomAddress,
    input  logic [INSTR_WIDTH-1:0] iRomData,
    output logic                   oPcHold,
    output logic                   oInstrValid,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic [9:0]             oInstrAddress,
    input  logic                   iDecodeReady
);

    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FILL_W = CNT_W + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             pend_vld_q, pend_vld_d;
    logic [9:0]       pend_addr_q, pend_addr_d;

    logic [INSTR_WIDTH-1:0] instr_mem_q [QUEUE_DEPTH];
    logic [9:0]             addr_mem_q  [QUEUE_DEPTH];

    logic              flush;
    logic [FILL_W-1:0] fill;
    logic              hold_raw;
    logic              issue;
    logic              push;
    logic              pop;

    always_comb begin
        flush    = iBranchTaken | iJumpTaken;
        // The in-flight word already owns a slot, so it counts toward the limit.
        fill     = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_vld_q};
        hold_raw = (fill >= FULL_LVL);

        oRomAddress = iIP;
        oPcHold     = hold_raw & ~flush & ~Reset;
        issue       = ~Reset & ~flush & ~hold_raw;
        push        = pend_vld_q & ~flush & ~Reset;
        oInstrValid = (count_q != '0) & ~flush & ~Reset;
        pop         = oInstrValid & iDecodeReady;

        oInstruction  = instr_mem_q[head_q];
        oInstrAddress = addr_mem_q[head_q];
    end

    always_comb begin
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        pend_vld_d  = issue;
        pend_addr_d = issue ? iIP : pend_addr_q;

        if (Reset || flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        count_q     <= count_d;
        head_q      <= head_d;
        tail_q      <= tail_d;
        pend_vld_q  <= pend_vld_d;
        pend_addr_q <= pend_addr_d;
    end

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge Clock) begin
        if (push) begin
            instr_mem_q[tail_q] <= iRomData;
            addr_mem_q[tail_q]  <= pend_addr_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (push && !pop) begin
            assert (count_q != FULL_CNT);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue with a PC-stage model and a one-cycle-latency ROM model.
module tb_fetch_queue;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [9:0]  iIP;
    logic        iBranchTaken;
    logic        iJumpTaken;
    logic [9:0]  oRomAddress;
    logic [15:0] iRomData;
    logic        oPcHold;
    logic        oInstrValid;
    logic [15:0] oInstruction;
    logic [9:0]  oInstrAddress;
    logic        iDecodeReady;

    logic [9:0]  pc;
    logic [9:0]  reset_pc;
    logic [9:0]  redirect_pc;

    int          checks   = 0;
    int          failures = 0;
    logic [9:0]  exp_q [$];

    always #5 Clock = ~Clock;

    fetch_queue #(
        .INSTR_WIDTH(16),
        .QUEUE_DEPTH(4)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iIP           (iIP),
        .iBranchTaken  (iBranchTaken),
        .iJumpTaken    (iJumpTaken),
        .oRomAddress   (oRomAddress),
        .iRomData      (iRomData),
        .oPcHold       (oPcHold),
        .oInstrValid   (oInstrValid),
        .oInstruction  (oInstruction),
        .oInstrAddress (oInstrAddress),
        .iDecodeReady  (iDecodeReady)
    );

    assign iIP = pc;

    // PC stage: loads on reset/redirect, otherwise counts unless held.
    always @(posedge Clock) begin
        if (Reset)                          pc <= reset_pc;
        else if (iBranchTaken | iJumpTaken) pc <= redirect_pc;
        else if (!oPcHold)                  pc <= pc + 10'd1;
    end

    always @(posedge Clock) begin
        iRomData <= 16'hA000 + {6'b0, oRomAddress};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Every instruction accepted by decode must match the front of the scoreboard.
    always @(negedge Clock) begin
        logic [9:0] e;
        if (!Reset && oInstrValid && iDecodeReady) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_pop", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("addr", {22'b0, oInstrAddress}, {22'b0, e});
                check_eq("data", {16'b0, oInstruction}, {16'b0, 16'hA000 + {6'b0, e}});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic push_seq(input logic [9:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 10'(i));
    endtask

    task automatic do_reset(input logic [9:0] rpc);
        reset_pc     = rpc;
        iDecodeReady = 1'b0;
        iBranchTaken = 1'b0;
        iJumpTaken   = 1'b0;
        Reset        = 1'b1;
        @(posedge Clock);
        #1;
        @(negedge Clock);
        check_eq("rst_vld", oInstrValid, 0);
        check_eq("rst_hold", oPcHold, 0);
        @(posedge Clock);
        #1;
        exp_q.delete();
        Reset = 1'b0;
    endtask

    task automatic drain(input int max_cyc, input bit chk_vld, input bit chk_nohold, input string tag);
        iDecodeReady = 1'b1;
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            @(posedge Clock);
            #1;
            if (exp_q.size() != 0) begin
                if (chk_vld)    check_eq({tag, "_vld"}, oInstrValid, 1);
                if (chk_nohold) check_eq({tag, "_nohold"}, oPcHold, 0);
            end
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
        iDecodeReady = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        iBranchTaken = 1'b0;
        iJumpTaken   = 1'b0;
        iDecodeReady = 1'b0;
        reset_pc     = 10'd0;
        redirect_pc  = 10'd0;
        step(2);

        // Streaming from address 0.
        do_reset(10'h000);
        push_seq(10'h000, 16);
        iDecodeReady = 1'b1;
        @(negedge Clock);
        check_eq("lat_c0", oInstrValid, 0);
        @(negedge Clock);
        check_eq("lat_c1", oInstrValid, 0);
        @(negedge Clock);
        check_eq("lat_c2", oInstrValid, 1);
        drain(60, 1'b1, 1'b1, "stream");

        // Backpressure: decode stalled from the start.
        do_reset(10'h000);
        push_seq(10'h000, 8);
        repeat (4) @(negedge Clock);
        check_eq("bp_hold_n3", oPcHold, 0);
        @(negedge Clock);
        check_eq("bp_hold_n4", oPcHold, 1);
        check_eq("bp_vld", oInstrValid, 1);
        check_eq("bp_head", {22'b0, oInstrAddress}, 32'h0);
        repeat (3) @(negedge Clock);
        check_eq("bp_hold_n7", oPcHold, 1);
        step(1);
        drain(60, 1'b0, 1'b0, "bp");

        // Jump flush with the queue holding 5..8.
        do_reset(10'h005);
        push_seq(10'h005, 4);
        step(6);
        check_eq("jmp_full_hold", oPcHold, 1);
        iJumpTaken   = 1'b1;
        redirect_pc  = 10'h040;
        iDecodeReady = 1'b1;
        #1;
        check_eq("jmp_vld_same", oInstrValid, 0);
        check_eq("jmp_hold_same", oPcHold, 0);
        step(1);
        iJumpTaken = 1'b0;
        exp_q.delete();
        #1;
        check_eq("jmp_vld_next", oInstrValid, 0);
        push_seq(10'h040, 5);
        drain(40, 1'b0, 1'b0, "jmp");

        // Two-cycle branch flush while streaming with a fetch in flight.
        do_reset(10'h010);
        push_seq(10'h010, 3);
        iDecodeReady = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        check_eq("br_pre_left", exp_q.size(), 0);
        iBranchTaken = 1'b1;
        redirect_pc  = 10'h200;
        #1;
        check_eq("br_vld_c1", oInstrValid, 0);
        step(1);
        check_eq("br_vld_c2", oInstrValid, 0);
        check_eq("br_hold_c2", oPcHold, 0);
        step(1);
        iBranchTaken = 1'b0;
        #1;
        check_eq("br_vld_after", oInstrValid, 0);
        push_seq(10'h200, 4);
        drain(40, 1'b0, 1'b0, "br");

        // Full queue then streaming across pointer and address wrap.
        do_reset(10'h3FC);
        push_seq(10'h3FC, 12);
        step(8);
        check_eq("full_hold", oPcHold, 1);
        check_eq("full_vld", oInstrValid, 1);
        drain(60, 1'b1, 1'b0, "full");

        // Reset with three buffered entries and one in flight.
        do_reset(10'h030);
        step(4);
        check_eq("mr_hold", oPcHold, 1);
        reset_pc = 10'h100;
        Reset    = 1'b1;
        #1;
        check_eq("mr_vld_rst", oInstrValid, 0);
        step(1);
        Reset = 1'b0;
        exp_q.delete();
        #1;
        check_eq("mr_vld_after", oInstrValid, 0);
        check_eq("mr_hold_after", oPcHold, 0);
        push_seq(10'h100, 5);
        drain(40, 1'b0, 1'b0, "mr");

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
